ss_arb5: RTL

Five-way round-robin bus arbiter for the Wishbone-style shared datapath. It turns five request lines into a registered one-hot grant vector. That vector drives the per-bit output mixers that select which master's signals reach the shared bus. The grant is held for the whole bus tenure, and a hold-time limit forces the owner off when other masters are waiting, so no master starves. Every change of owner inserts one dead cycle, so the mixers never see two grants at once.

---
 rtl/ss_arb5_if.sv | 36 +++
 rtl/ss_arb5.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ss_arb5_if.sv
// ---------------------------------------------------------------------------
// ss_arb5_if
// Request/grant bundle between the five bus masters and the round-robin
// arbiter. The arbiter side uses the slave modport, the requesting side
// (masters or a testbench) uses the master modport.
//
// Signals:
//   req      [4:0]  request from master i, held for the whole tenure
//   gnt      [4:0]  registered one-hot or all-zero grant
//   gnt_id   [2:0]  encoded owner index, 0 when idle
//   gnt_vld         high when any gnt bit is set
//   preempt         one-cycle pulse when the owner is forced off by the hold limit
// ---------------------------------------------------------------------------
interface ss_arb5_if;
    logic [4:0] req;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_vld,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_vld,
        output preempt
    );
endinterface

// File: rtl/ss_arb5.sv
// ---------------------------------------------------------------------------
// ss_arb5
// Five-way round-robin arbiter for the shared Wishbone-style datapath.
// A grant is held for the whole bus tenure. When other masters are waiting,
// the owner is forced off after MAX_HOLD cycles. Every change of owner passes
// through at least one all-zero grant cycle, so the output mixers never see
// two grants at once.
//
// Parameters:
//   MAX_HOLD  maximum grant cycles while another request is pending (2..31)
//   CW        hold counter width, 2**CW > MAX_HOLD
//
// Ports:
//   wb_clk_i  system clock, rising edge
//   wb_rst_i  asynchronous active-low reset
//   bus       ss_arb5_if slave modport (req in; gnt/gnt_id/gnt_vld/preempt out)
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module ss_arb5 #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    ss_arb5_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic [4:0]    gnt_q, gnt_d;
    logic [2:0]    gnt_id_q, gnt_id_d;
    logic          gnt_vld_q, gnt_vld_d;
    logic          preempt_q, preempt_d;
    logic [2:0]    last_q, last_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    logic [2:0]    win;
    logic          win_found;
    logic [3:0]    cand;
    logic          others_pending;
    logic          at_limit;

    // Round-robin search: visit last+1 .. last+5 (mod 5), so the previous
    // owner is only reached last and wins only when it is the sole requester.
    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        cand      = 4'd0;
        for (int off = 1; off <= 5; off++) begin
            cand = {1'b0, last_q} + 4'(off);
            if (cand >= 4'd5) begin
                cand = cand - 4'd5;
            end
            if (!win_found && bus.req[cand[2:0]]) begin
                win_found = 1'b1;
                win       = cand[2:0];
            end
        end
    end

    assign others_pending = (bus.req & ~gnt_q) != 5'd0;
    assign at_limit       = (hold_cnt_q == HOLD_LAST);

    // Next-state logic. Release is tested before the hold limit, so a master
    // that drops req on the limit cycle leaves normally and preempt stays low.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        gnt_vld_d  = gnt_vld_q;
        preempt_d  = 1'b0;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = GRANT;
                    gnt_d      = 5'd1 << win;
                    gnt_id_d   = win;
                    gnt_vld_d  = 1'b1;
                    last_d     = win;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!bus.req[gnt_id_q]) begin
                    state_d   = IDLE;
                    gnt_d     = 5'd0;
                    gnt_id_d  = 3'd0;
                    gnt_vld_d = 1'b0;
                end else if (at_limit && others_pending) begin
                    state_d   = IDLE;
                    gnt_d     = 5'd0;
                    gnt_id_d  = 3'd0;
                    gnt_vld_d = 1'b0;
                    preempt_d = 1'b1;
                end else if (!at_limit) begin
                    // Saturates at the limit when nobody else is waiting.
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = 5'd0;
                gnt_id_d  = 3'd0;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    // Pointer resets to 4 so the first search after reset starts at master 0.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= 5'd0;
            gnt_id_q   <= 3'd0;
            gnt_vld_q  <= 1'b0;
            preempt_q  <= 1'b0;
            last_q     <= 3'd4;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            gnt_vld_q  <= gnt_vld_d;
            preempt_q  <= preempt_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.preempt = preempt_q;

endmodule
